prt_riscv_irq_ctl: RTL and testbench

- Interrupt controller placed between the platform interrupt sources and the single IRQ input of the RISC-V core inside prt_riscv_top.
- Synchronises up to P_SRC request lines and latches them as pending, masks and prioritises them, then presents one request at a time to the core.
- The core claims the request with an acknowledge and completes it with an end-of-interrupt.
- Software configures the block through a small register port on the peripheral bus.

---
 rtl/prt_riscv_irq_ctl_if.sv | 33 +++
 rtl/prt_riscv_irq_ctl.sv | 193 +++++++++++++++++++
 tb/tb_prt_riscv_irq_ctl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/prt_riscv_irq_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : prt_riscv_irq_ctl_if
// Purpose  : Configuration register port and core IRQ handshake bundle of
//            the RISC-V interrupt controller.
// Revision : 1.0  initial release
// ============================================================================
interface prt_riscv_irq_ctl_if;
  // peripheral-bus register port
  logic        cfg_wr_in;
  logic        cfg_rd_in;
  logic [1:0]  cfg_adr_in;
  logic [31:0] cfg_dat_in;
  logic [31:0] cfg_dat_out;
  // core interrupt handshake
  logic        irq_out;
  logic [3:0]  irq_id_out;
  logic        irq_ack_in;
  logic        irq_eoi_in;

  // bus master and core side: drives strobes/ack/eoi, receives requests
  modport master (
    output cfg_wr_in, cfg_rd_in, cfg_adr_in, cfg_dat_in, irq_ack_in, irq_eoi_in,
    input  cfg_dat_out, irq_out, irq_id_out
  );

  // controller side
  modport slave (
    input  cfg_wr_in, cfg_rd_in, cfg_adr_in, cfg_dat_in, irq_ack_in, irq_eoi_in,
    output cfg_dat_out, irq_out, irq_id_out
  );
endinterface
`default_nettype wire

// File: rtl/prt_riscv_irq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : prt_riscv_irq_ctl
// Purpose  : Synchronises, latches, masks and prioritises up to P_SRC
//            interrupt sources and presents one request at a time to the
//            core, with claim (ack) and completion (eoi) handshake.
// Revision : 1.0  initial release
// ============================================================================
module prt_riscv_irq_ctl #(
  parameter int P_SRC  = 8,
  parameter int P_SYNC = 2
) (
  input  wire logic             clk_in,
  input  wire logic             rst_in,
  input  wire logic [P_SRC-1:0] src_in,
  prt_riscv_irq_ctl_if.slave    bus
);

  localparam logic [1:0] c_adr_enable  = 2'd0;
  localparam logic [1:0] c_adr_mode    = 2'd1;
  localparam logic [1:0] c_adr_pending = 2'd2;
  localparam logic [1:0] c_adr_ctrl    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_irq;
  logic [3:0]       r_id;

  logic [P_SRC-1:0] r_sync [P_SYNC];
  logic [P_SRC-1:0] r_s_prev;
  logic [P_SRC-1:0] r_enable;
  logic [P_SRC-1:0] r_mode;
  logic [P_SRC-1:0] r_pend;
  logic             r_gie;
  logic [31:0]      r_rd_dat;

  logic [P_SRC-1:0] w_s;
  logic [P_SRC-1:0] w_rise;
  logic [P_SRC-1:0] w_w1c;
  logic [P_SRC-1:0] w_pend_nxt;
  logic [P_SRC-1:0] w_elig;
  logic             w_any;
  logic [3:0]       w_win_id;
  logic             w_cur_elig;
  logic             w_ack_take;
  logic             w_wr_enable;
  logic             w_wr_mode;
  logic             w_wr_ctrl;
  logic [31:0]      w_rd_data;
  logic             w_unused_dat;

  // Synchroniser chains: one flop per stage for every source line
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < P_SYNC; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= src_in;
      for (int k = 1; k < P_SYNC; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s    = r_sync[P_SYNC-1];
  assign w_rise = w_s & ~r_s_prev;

  // Previous synchronised value, used for rising-edge detection
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_s_prev <= '0;
    else        r_s_prev <= w_s;
  end

  // Register write decode; W1C only matters for edge sources (see pending)
  assign w_wr_enable = bus.cfg_wr_in && (bus.cfg_adr_in == c_adr_enable);
  assign w_wr_mode   = bus.cfg_wr_in && (bus.cfg_adr_in == c_adr_mode);
  assign w_wr_ctrl   = bus.cfg_wr_in && (bus.cfg_adr_in == c_adr_ctrl);
  assign w_w1c       = (bus.cfg_wr_in && (bus.cfg_adr_in == c_adr_pending)) ?
                       bus.cfg_dat_in[P_SRC-1:0] : '0;
  // Upper data bits and unused CTRL bits are intentionally ignored
  assign w_unused_dat = ^bus.cfg_dat_in;

  // The core claims the presented ID only while a request is outstanding
  assign w_ack_take = (r_state == ST_REQ) && bus.irq_ack_in;

  // Per-source next pending value: edge sources latch, level sources follow s
  generate
    for (genvar i = 0; i < P_SRC; i++) begin : g_pend
      logic w_clr;
      assign w_clr = w_w1c[i] | (w_ack_take && (r_id == 4'(i)));
      // a new edge in the same cycle as a clear keeps the bit set
      assign w_pend_nxt[i] = r_mode[i] ? (w_rise[i] | (r_pend[i] & ~w_clr))
                                       : w_s[i];
    end
  endgenerate

  // Configuration and pending registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_enable <= '0;
      r_mode   <= '0;
      r_gie    <= 1'b0;
      r_pend   <= '0;
    end else begin
      if (w_wr_enable) r_enable <= bus.cfg_dat_in[P_SRC-1:0];
      if (w_wr_mode)   r_mode   <= bus.cfg_dat_in[P_SRC-1:0];
      if (w_wr_ctrl)   r_gie    <= bus.cfg_dat_in[0];
      r_pend <= w_pend_nxt;
    end
  end

  assign w_elig = r_pend & r_enable & {P_SRC{r_gie}};
  assign w_any  = |w_elig;

  // Fixed priority: lowest index wins; also tracks eligibility of latched ID
  always_comb begin
    w_win_id   = 4'd0;
    w_cur_elig = 1'b0;
    for (int i = P_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_id = 4'(i);
    end
    for (int i = 0; i < P_SRC; i++) begin
      if (r_id == 4'(i)) w_cur_elig = w_elig[i];
    end
  end

  // Request/claim/service sequencer with registered IRQ and ID outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_irq   <= 1'b0;
      r_id    <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id    <= w_win_id;
            r_irq   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // the latched ID is not re-arbitrated while waiting for the claim
          if (bus.irq_ack_in) begin
            r_irq   <= 1'b0;
            r_state <= ST_SERV;
          end else if (!w_cur_elig) begin
            r_irq   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SERV: begin
          r_irq <= 1'b0;
          if (bus.irq_eoi_in) r_state <= ST_IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-data mux; unimplemented bits read as zero
  always_comb begin
    w_rd_data = 32'd0;
    case (bus.cfg_adr_in)
      c_adr_enable:  w_rd_data[P_SRC-1:0] = r_enable;
      c_adr_mode:    w_rd_data[P_SRC-1:0] = r_mode;
      c_adr_pending: w_rd_data[P_SRC-1:0] = r_pend;
      c_adr_ctrl: begin
        w_rd_data[0]   = r_gie;
        w_rd_data[1]   = (r_state != ST_IDLE);
        w_rd_data[7:4] = r_id;
      end
      default: w_rd_data = 32'd0;
    endcase
  end

  // Read data is registered and held until the next read strobe
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)              r_rd_dat <= 32'd0;
    else if (bus.cfg_rd_in)  r_rd_dat <= w_rd_data;
  end

  assign bus.cfg_dat_out = r_rd_dat;
  assign bus.irq_out     = r_irq;
  assign bus.irq_id_out  = r_id;

endmodule
`default_nettype wire

// File: tb/tb_prt_riscv_irq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prt_riscv_irq_ctl
// Purpose  : Directed self-checking bench for prt_riscv_irq_ctl with
//            scoreboard queues for read data and presented interrupt IDs.
// Revision : 1.0  initial release
// ============================================================================
module tb_prt_riscv_irq_ctl;
  localparam int P_SRC  = 8;
  localparam int P_SYNC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [P_SRC-1:0] src;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_q[$];
  logic [3:0]  irq_q[$];

  prt_riscv_irq_ctl_if bus();

  prt_riscv_irq_ctl #(.P_SRC(P_SRC), .P_SYNC(P_SYNC)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .src_in (src),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] adr, input logic [31:0] dat);
    bus.cfg_wr_in  = 1'b1;
    bus.cfg_adr_in = adr;
    bus.cfg_dat_in = dat;
    tick();
    bus.cfg_wr_in  = 1'b0;
    bus.cfg_dat_in = 32'd0;
  endtask

  task automatic cfg_read(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.cfg_rd_in  = 1'b1;
    bus.cfg_adr_in = adr;
    tick();
    bus.cfg_rd_in  = 1'b0;
    chk(tag, bus.cfg_dat_out, rd_q.pop_front());
  endtask

  // Wait (bounded) for a request, check its latency and the queued ID
  task automatic wait_irq(input string tag, input int exp_lat);
    int cnt = 0;
    logic [3:0] exp_id;
    while (bus.irq_out !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_lat"}, cnt, exp_lat);
    exp_id = (irq_q.size() > 0) ? irq_q.pop_front() : 4'hx;
    chk({tag, "_id"}, {28'd0, bus.irq_id_out}, {28'd0, exp_id});
  endtask

  task automatic pulse_ack();
    bus.irq_ack_in = 1'b1;
    tick();
    bus.irq_ack_in = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.irq_eoi_in = 1'b1;
    tick();
    bus.irq_eoi_in = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    src = '0;
    bus.cfg_wr_in  = 1'b0;
    bus.cfg_rd_in  = 1'b0;
    bus.cfg_adr_in = 2'd0;
    bus.cfg_dat_in = 32'd0;
    bus.irq_ack_in = 1'b0;
    bus.irq_eoi_in = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_irq", {31'd0, bus.irq_out}, 32'd0);
    chk("rst_id", {28'd0, bus.irq_id_out}, 32'd0);
    chk("rst_dat", bus.cfg_dat_out, 32'd0);
    rst = 1'b0;
    tick();
    cfg_read("rst_enable", 2'd0, 32'h0);
    cfg_read("rst_mode", 2'd1, 32'h0);
    cfg_read("rst_pend", 2'd2, 32'h0);
    cfg_read("rst_ctrl", 2'd3, 32'h0);

    // single edge source: latency 3, ack clears pending, eoi clears busy
    cfg_write(2'd1, 32'hFF);
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd3, 32'h01);
    cfg_read("t1_mode", 2'd1, 32'hFF);
    src[0] = 1'b1;
    irq_q.push_back(4'd0);
    tick();
    src[0] = 1'b0;
    wait_irq("t1_irq", 3);
    pulse_ack();
    chk("t1_ack_irq", {31'd0, bus.irq_out}, 32'd0);
    cfg_read("t1_pend", 2'd2, 32'h00);
    cfg_read("t1_busy", 2'd3, 32'h03);
    pulse_eoi();
    cfg_read("t1_idle", 2'd3, 32'h01);

    // simultaneous edges on 3 and 2: lowest index first, then 3 one cycle after eoi
    cfg_write(2'd0, 32'h0C);
    src[3] = 1'b1;
    src[2] = 1'b1;
    irq_q.push_back(4'd2);
    irq_q.push_back(4'd3);
    tick();
    wait_irq("t2_first", 3);
    pulse_ack();
    pulse_eoi();
    wait_irq("t2_second", 1);
    pulse_ack();
    pulse_eoi();
    src[3] = 1'b0;
    src[2] = 1'b0;
    repeat (3) tick();
    cfg_read("t2_pend", 2'd2, 32'h00);

    // level source 5 drops before ack: withdrawal 3 cycles after the drop
    cfg_write(2'd1, 32'hDF);
    cfg_write(2'd0, 32'h20);
    src[5] = 1'b1;
    irq_q.push_back(4'd5);
    tick();
    wait_irq("t3_irq", 3);
    src[5] = 1'b0;
    tick();
    cnt = 0;
    while (bus.irq_out === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("t3_withdraw_lat", cnt, 3);
    cfg_read("t3_ctrl", 2'd3, 32'h51);
    cfg_read("t3_pend", 2'd2, 32'h00);

    // edge source 1 pending while masked, enable late, then W1C withdraws
    cfg_write(2'd1, 32'hFF);
    cfg_write(2'd0, 32'h00);
    src[1] = 1'b1;
    tick();
    src[1] = 1'b0;
    repeat (4) tick();
    chk("t4_masked_irq", {31'd0, bus.irq_out}, 32'd0);
    cfg_read("t4_pend", 2'd2, 32'h02);
    irq_q.push_back(4'd1);
    cfg_write(2'd0, 32'h02);
    wait_irq("t4_irq", 1);
    cfg_write(2'd2, 32'h02);
    tick();
    chk("t4_w1c_irq", {31'd0, bus.irq_out}, 32'd0);
    cfg_read("t4_ctrl", 2'd3, 32'h11);

    // W1C on bit 4 in the same cycle a new edge sets it: set wins
    cfg_write(2'd0, 32'h00);
    src[4] = 1'b1;
    tick();
    src[4] = 1'b0;
    repeat (3) tick();
    cfg_read("t5_pend_pre", 2'd2, 32'h10);
    src[4] = 1'b1;
    tick();
    tick();
    cfg_write(2'd2, 32'h10);
    src[4] = 1'b0;
    cfg_read("t5_setwins", 2'd2, 32'h10);
    cfg_write(2'd2, 32'h10);
    cfg_read("t5_w1c", 2'd2, 32'h00);

    // asynchronous reset while in service, later eoi ignored
    cfg_write(2'd0, 32'h02);
    src[1] = 1'b1;
    irq_q.push_back(4'd1);
    tick();
    src[1] = 1'b0;
    wait_irq("t6_irq", 3);
    pulse_ack();
    cfg_read("t6_serv", 2'd3, 32'h13);
    rst = 1'b1;
    #1;
    chk("t6_rst_irq", {31'd0, bus.irq_out}, 32'd0);
    chk("t6_rst_id", {28'd0, bus.irq_id_out}, 32'd0);
    chk("t6_rst_dat", bus.cfg_dat_out, 32'd0);
    tick();
    rst = 1'b0;
    cfg_read("t6_enable", 2'd0, 32'h0);
    cfg_read("t6_mode", 2'd1, 32'h0);
    cfg_read("t6_pend", 2'd2, 32'h0);
    pulse_eoi();
    tick();
    cfg_read("t6_ctrl", 2'd3, 32'h0);
    chk("t6_final_irq", {31'd0, bus.irq_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
